// File: rtl/alu_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : alu_arbiter
// Brief   : Round-robin arbiter/sequencer sharing one combinational 8-bit ALU
//           between NREQ requesters. Grants one op, registers it onto the ALU
//           inputs, captures the result a cycle later and returns it on a
//           shared response channel tagged with the requester index.
// Revision: 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 8,
    localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [2*NREQ-1:0]   req_op,
    input  logic [W*NREQ-1:0]   req_a,
    input  logic [W*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]     req_ready,
    output logic [1:0]          alu_op,
    output logic [W-1:0]        alu_a,
    output logic [W-1:0]        alu_b,
    input  logic [W-1:0]        alu_o,
    input  logic                alu_cout,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IW-1:0]       rsp_id,
    output logic [W-1:0]        rsp_data,
    output logic                rsp_cout,
    output logic                rsp_zero,
    output logic                busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          state_q;
    logic [IW-1:0]   ptr_q;
    logic [IW-1:0]   id_q;
    logic [1:0]      alu_op_q;
    logic [W-1:0]    alu_a_q;
    logic [W-1:0]    alu_b_q;
    logic [IW-1:0]   rsp_id_q;
    logic [W-1:0]    rsp_data_q;
    logic            rsp_cout_q;
    logic            rsp_zero_q;

    logic            gnt_found;
    logic [IW-1:0]   gnt_idx;
    logic [IW:0]     cand;
    logic [IW:0]     ptr_inc;
    logic [IW-1:0]   ptr_d;
    logic [1:0]      gnt_op;
    logic [W-1:0]    gnt_a;
    logic [W-1:0]    gnt_b;

    // Round-robin search: first valid requester starting at ptr, wrapping mod NREQ.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = {1'b0, ptr_q} + (IW+1)'(i);
            if (cand >= (IW+1)'(NREQ)) begin
                cand = cand - (IW+1)'(NREQ);
            end
            if (!gnt_found && req_valid[cand[IW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[IW-1:0];
            end
        end
    end

    // Next pointer (one past the winner) and the winner's payload.
    always_comb begin
        ptr_inc = {1'b0, gnt_idx} + (IW+1)'(1);
        ptr_d   = (ptr_inc >= (IW+1)'(NREQ)) ? '0 : ptr_inc[IW-1:0];
        gnt_op  = req_op[2*int'(gnt_idx) +: 2];
        gnt_a   = req_a[W*int'(gnt_idx) +: W];
        gnt_b   = req_b[W*int'(gnt_idx) +: W];
    end

    // One-hot grant, only offered while idle and out of reset.
    always_comb begin
        req_ready = '0;
        if ((state_q == S_IDLE) && !rst && gnt_found) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    // Sequencer: IDLE grants and loads the ALU, EXEC captures the result,
    // RESP holds the response until the consumer takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            id_q       <= '0;
            alu_op_q   <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            rsp_id_q   <= '0;
            rsp_data_q <= '0;
            rsp_cout_q <= 1'b0;
            rsp_zero_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (gnt_found) begin
                        alu_op_q <= gnt_op;
                        alu_a_q  <= gnt_a;
                        alu_b_q  <= gnt_b;
                        id_q     <= gnt_idx;
                        ptr_q    <= ptr_d;
                        state_q  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    rsp_data_q <= alu_o;
                    rsp_zero_q <= (alu_o == '0);
                    rsp_id_q   <= id_q;
                    // Carry is only meaningful for add/sub (op[1] == 0).
                    rsp_cout_q <= ~alu_op_q[1] & alu_cout;
                    state_q    <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign alu_op    = alu_op_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_cout  = rsp_cout_q;
    assign rsp_zero  = rsp_zero_q;
    assign busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_alu_arbiter
// Brief   : Self-checking bench for alu_arbiter with a behavioural ALU and a
//           spec-level reference model of arbitration and arithmetic.
// Revision: 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int IW   = 2;

    logic                clk;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [2*NREQ-1:0]   req_op;
    logic [W*NREQ-1:0]   req_a;
    logic [W*NREQ-1:0]   req_b;
    logic [NREQ-1:0]     req_ready;
    logic [1:0]          alu_op;
    logic [W-1:0]        alu_a;
    logic [W-1:0]        alu_b;
    logic [W-1:0]        alu_o;
    logic                alu_cout;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IW-1:0]       rsp_id;
    logic [W-1:0]        rsp_data;
    logic                rsp_cout;
    logic                rsp_zero;
    logic                busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int m_ptr = 0;
    int exp_next = -1;

    alu_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .alu_op    (alu_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_o     (alu_o),
        .alu_cout  (alu_cout),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_cout  (rsp_cout),
        .rsp_zero  (rsp_zero),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Behavioural ALU; carry driven high for logic ops so masking is visible.
    always_comb begin
        alu_o    = '0;
        alu_cout = 1'b0;
        case (alu_op)
            2'b00: {alu_cout, alu_o} = {1'b0, alu_a} + {1'b0, alu_b};
            2'b01: begin alu_o = alu_a - alu_b; alu_cout = (alu_a >= alu_b); end
            2'b10: begin alu_o = alu_a & alu_b; alu_cout = 1'b1; end
            default: begin alu_o = alu_a | alu_b; alu_cout = 1'b1; end
        endcase
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int k, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        req_op[2*k +: 2] = op;
        req_a[W*k +: W]  = a;
        req_b[W*k +: W]  = b;
    endtask

    function automatic int pick();
        for (int i = 0; i < NREQ; i++) begin
            int k;
            k = (m_ptr + i) % NREQ;
            if (req_valid[k]) return k;
        end
        return -1;
    endfunction

    // One full transaction from IDLE back to IDLE; hold = cycles of rsp_ready=0 in RESP.
    task automatic serve(input int hold, output int g);
        logic [1:0] op;
        logic [7:0] a, b, ed;
        logic       ec;
        int         s;
        g = pick();
        if (g < 0) return;
        op = req_op[2*g +: 2];
        a  = req_a[W*g +: W];
        b  = req_b[W*g +: W];
        case (op)
            2'b00: begin s = int'(a) + int'(b); ed = s[7:0]; ec = (s >= 256); end
            2'b01: begin s = int'(a) - int'(b) + 256; ed = s[7:0]; ec = (a >= b); end
            2'b10: begin ed = a & b; ec = 1'b0; end
            default: begin ed = a | b; ec = 1'b0; end
        endcase
        chk("req_ready_grant", 32'(req_ready), 32'(1 << g));
        chk("busy_idle", 32'(busy), 0);
        rsp_ready = (hold == 0);
        @(posedge clk); #1;
        if (exp_next >= 0) chk("grant_spacing", cyc, exp_next);
        exp_next = cyc + 3 + hold;
        m_ptr = (g + 1) % NREQ;
        chk("alu_op", 32'(alu_op), 32'(op));
        chk("alu_a", 32'(alu_a), 32'(a));
        chk("alu_b", 32'(alu_b), 32'(b));
        chk("req_ready_exec", 32'(req_ready), 0);
        chk("rsp_valid_exec", 32'(rsp_valid), 0);
        // Granted payload may now change freely; ALU inputs must not follow it.
        set_req(g, 2'($urandom), 8'($urandom), 8'($urandom));
        @(posedge clk); #1;
        chk("rsp_valid", 32'(rsp_valid), 1);
        chk("rsp_id", 32'(rsp_id), 32'(g));
        chk("rsp_data", 32'(rsp_data), 32'(ed));
        chk("rsp_cout", 32'(rsp_cout), 32'(ec));
        chk("rsp_zero", 32'(rsp_zero), 32'(ed == 8'h00));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(rsp_valid), 1);
            chk("hold_data", 32'(rsp_data), 32'(ed));
            chk("hold_id", 32'(rsp_id), 32'(g));
            chk("hold_req_ready", 32'(req_ready), 0);
            chk("hold_busy", 32'(busy), 1);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("rsp_valid_drop", 32'(rsp_valid), 0);
        chk("busy_done", 32'(busy), 0);
        chk("rsp_data_kept", 32'(rsp_data), 32'(ed));
        chk("alu_a_kept", 32'(alu_a), 32'(a));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_alu"}, {8'h0, 6'h0, alu_op, alu_a, alu_b}, 0);
        chk({tag, "_rsp"}, {19'h0, rsp_valid, IW'(rsp_id), rsp_data, rsp_cout, rsp_zero}, 0);
        chk({tag, "_rdy_busy"}, {27'h0, req_ready, busy}, 0);
    endtask

    initial begin
        int g;
        rst       = 1'b1;
        req_valid = '1;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;
        req_valid = '0;
        @(posedge clk); #1;
        chk("idle_ready", 32'(req_ready), 0);
        chk("idle_busy", 32'(busy), 0);

        // Add 7F+01 from requester 0
        set_req(0, 2'b00, 8'h7F, 8'h01); req_valid = 4'b0001; #1;
        serve(0, g);
        // Add overflow from requester 2
        set_req(2, 2'b00, 8'hFF, 8'h01); req_valid = 4'b0100; #1;
        serve(0, g);
        // Sub with borrow, then without
        set_req(3, 2'b01, 8'h05, 8'h07); req_valid = 4'b1000; #1;
        serve(0, g);
        set_req(1, 2'b01, 8'h07, 8'h05); req_valid = 4'b0010; #1;
        serve(0, g);
        // Logic ops: carry must be forced to 0
        set_req(0, 2'b10, 8'hF0, 8'h3C); req_valid = 4'b0001; #1;
        serve(0, g);
        set_req(2, 2'b11, 8'hF0, 8'h3C); req_valid = 4'b0100; #1;
        serve(0, g);

        // All requesters valid: strict rotation, 3-cycle spacing
        for (int k = 0; k < NREQ; k++) set_req(k, 2'($urandom), 8'($urandom), 8'($urandom));
        req_valid = 4'b1111; #1;
        for (int n = 0; n < 6; n++) begin
            int start;
            start = m_ptr;
            serve(0, g);
            chk("rotation", 32'(g), 32'(start));
        end

        // Backpressure for 5 cycles
        serve(5, g);
        serve(0, g);

        // Async reset during EXEC
        req_valid = 4'b0001;
        set_req(0, 2'b00, 8'h12, 8'h34);
        exp_next = -1;
        @(posedge clk); #1;
        chk("pre_reset_busy", 32'(busy), 1);
        #2 rst = 1'b1;
        #1;
        chk_all_zero("async_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        req_valid = '0;
        m_ptr = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("no_rsp_after_reset", 32'(rsp_valid), 0);
        end
        req_valid = 4'b1111; #1;
        serve(0, g);

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            for (int k = 0; k < NREQ; k++) set_req(k, 2'($urandom), 8'($urandom), 8'($urandom));
            req_valid = 4'($urandom_range(0, 15));
            #1;
            if (req_valid == '0) begin
                @(posedge clk); #1;
                chk("rand_idle_ready", 32'(req_ready), 0);
                chk("rand_idle_busy", 32'(busy), 0);
                exp_next = -1;
            end else begin
                serve($urandom_range(0, 2), g);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 8-bit `alu` instance between NREQ requesters.
- Requesters present op/operands with a valid/ready handshake. The arbiter registers the granted operation onto the ALU inputs and captures the result one cycle later. It then returns the result on a single shared response channel tagged with the requester index.
- Sits between the datapath clients and the combinational `alu`.

Parameters:
NREQ, 4, number of requesters (2..8); index width IW = clog2(NREQ), minimum 1
W, 8, operand width; fixed to match `alu`, no other value supported

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
req_valid  input  NREQ  per-requester request valid
req_op  input  2*NREQ  per-requester op, requester k at [2k+1:2k]; 00 add, 01 sub, 10 and, 11 or
req_a  input  W*NREQ  per-requester operand A, requester k at [W*k+W-1:W*k]
req_b  input  W*NREQ  per-requester operand B, same packing
req_ready  output  NREQ  one-hot grant; request k accepted when req_valid[k] & req_ready[k]
alu_op  output  2  to alu.op
alu_a  output  W  to alu.i0
alu_b  output  W  to alu.i1
alu_o  input  W  from alu.o
alu_cout  input  1  from alu.cout
rsp_valid  output  1  response valid
rsp_ready  input  1  response consumer ready
rsp_id  output  IW  index of the requester that issued the response
rsp_data  output  W  ALU result
rsp_cout  output  1  carry (add) / no-borrow (sub); 0 for and/or
rsp_zero  output  1  rsp_data == 0
busy  output  1  state != IDLE

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, ptr=0.
  - alu_op/alu_a/alu_b=0.
  - rsp_valid=0, rsp_id=0, rsp_data=0, rsp_cout=0, rsp_zero=0.
  - req_ready=0, busy=0.
  - Reset mid-operation abandons the in-flight op; no response is produced for it.
- FSM: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - If any req_valid, select g = first k with req_valid[k], searching ptr, ptr+1, ... mod NREQ.
  - req_ready = one-hot(g), combinational, asserted only in IDLE. Otherwise req_ready=0.
  - On the grant edge: alu_op<=req_op[g], alu_a<=req_a[g], alu_b<=req_b[g], id<=g, ptr<=(g+1) mod NREQ, state<=EXEC.
  - No request: stay in IDLE, ptr unchanged.
- EXEC, one cycle, ALU settles on the registered inputs. On the edge:
  - rsp_data<=alu_o, rsp_zero<=(alu_o==0), rsp_id<=id.
  - rsp_cout<=alu_cout if alu_op[1]==0, else 0.
  - state<=RESP.
- RESP:
  - rsp_valid=1; all rsp_* held stable until rsp_ready.
  - On rsp_valid & rsp_ready: state<=IDLE. rsp_* keep their last values and rsp_valid drops.
  - Requests arriving during EXEC/RESP wait. req_ready stays 0, so requesters must hold valid and payload.
- Latency:
  - Grant at edge T; rsp_valid visible after edge T+1.
  - With rsp_ready held at 1, next grant at edge T+3.
  - Peak throughput 1 op per 3 cycles.
- alu_op/alu_a/alu_b hold their values after completion until the next grant. No spurious toggling.
- Fairness: a requester holding valid is granted within NREQ grants. The just-served requester has lowest priority next round.
- Arithmetic is mod 2^W.
  - sub: rsp_data = A - B (two's complement); rsp_cout = 1 iff A >= B unsigned.
  - add: rsp_cout = bit W of A + B.
- A requester dropping req_valid while not granted is legal and has no effect. Withdrawal is not possible after the grant edge.
- rsp_ready asserted outside RESP is ignored.

Test Plan:
1. Reset, then req_valid=0001, op=00, A=8'h7F, B=8'h01 -> req_ready=0001 one cycle; next cycle rsp_valid=1, rsp_id=0, rsp_data=8'h80, rsp_cout=0, rsp_zero=0.
2. Add overflow A=8'hFF, B=8'h01 from requester 2 -> rsp_data=8'h00, rsp_cout=1, rsp_zero=1, rsp_id=2. Sub A=8'h05, B=8'h07 -> rsp_data=8'hFE, rsp_cout=0. Sub A=8'h07, B=8'h05 -> rsp_data=8'h02, rsp_cout=1.
3. Logic: and 8'hF0 & 8'h3C -> rsp_data=8'h30, rsp_cout=0. or -> rsp_data=8'hFC, rsp_cout=0.
4. All four requesters continuously valid, rsp_ready=1 -> grant order 0,1,2,3,0,1 with rsp_id matching. Grants spaced exactly 3 cycles apart.
5. Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_* stable, req_ready=0 throughout, busy=1. One cycle after rsp_ready=1, state IDLE and next grant issued.
6. Assert rst during EXEC -> all outputs 0 immediately (async), no rsp_valid afterwards. ptr=0, so the next grant with req_valid=1111 goes to requester 0.
